// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch stage and the decode control unit.
package rv32i_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0: what the IF/ID boundary shows before anything real is fetched
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes (instr[6:0]); decode drives its control decoder from these
    typedef enum logic [6:0] {
        OP_LOAD     = 7'b0000011,
        OP_MISC_MEM = 7'b0001111,
        OP_IMM      = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_STORE    = 7'b0100011,
        OP_REG      = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_BRANCH   = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111,
        OP_SYSTEM   = 7'b1110011
    } opcode_e;

    // One buffered fetch: the instruction word and the address it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    // Opcode field of an instruction word
    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {pc, instr} entries between imem and decode.
// A synchronous clear drops everything (wrong-path flush) and wins over push/pop.
module fetch_fifo
#(
    parameter int DEPTH = 2
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  rv32i_pkg::fetch_entry_t       entry_i,
    input  logic                          pop_i,
    input  logic                          clear_i,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output rv32i_pkg::fetch_entry_t       head_o
);

    import rv32i_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop, full;

    // Advance a pointer, wrapping after the last slot (DEPTH need not be a power of two)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~clear_i & (count_q != '0);
    assign do_push = push_i & ~clear_i & (~full | do_pop);

    // Pointer and occupancy next-state; a full FIFO may push and pop together
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer/count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; reset to a NOP at pc 0 so the idle boundary shows NOP/0/4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // The fetch stage must never ask to push into a full FIFO that is not draining
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !clear_i && full && !do_pop));

    // Decode only pops when an entry is visible
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && !clear_i && count_q == '0));

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: owns the PC, issues reads to a
// 1-cycle synchronous imem, buffers responses and hands {instr, pc, pc+4}
// to decode over valid/ready. EX redirects flush the wrong path.
// XLEN should match rv32i_pkg::XLEN, which sizes the buffered entries.
module fetch_stage
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
)(
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
);

    import rv32i_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            kill_q, kill_d;

    logic [CW-1:0]   count;
    fetch_entry_t    head, push_entry;
    logic            valid, pop, push, issue;
    logic [OW-1:0]   occupancy;

    // A redirect hides the current head and blocks the handshake for this cycle
    assign valid = (count != '0) & ~redirect_valid;
    assign pop   = valid & id_ready;

    // Slots that will be taken after this edge: buffered + in flight - leaving now.
    // Counting the pop here is what lets a full FIFO keep one fetch per cycle,
    // and it is why id_ready reaches imem_req combinationally.
    assign occupancy = OW'(count) + OW'(inflight_q) - OW'(pop);

    // rst_n gates the request so it drops the instant reset asserts
    assign issue = rst_n & ~redirect_valid & (occupancy < OW'(DEPTH));

    // Response for last cycle's request, unless it belongs to a flushed path
    assign push       = inflight_q & ~kill_q;
    assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

    // PC and in-flight tracking next-state; redirect overrides issue
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        kill_d     = 1'b0;
        if (redirect_valid) begin
            pc_d   = redirect_pc & ~XLEN'(3);
            kill_d = inflight_q;
        end else if (issue) begin
            pc_d     = pc_q + XLEN'(4);
            req_pc_d = pc_q;
        end
    end

    // PC, in-flight request address and flush flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .clear_i (redirect_valid),
        .count_o (count),
        .head_o  (head)
    );

    assign imem_req    = issue;
    assign imem_addr   = pc_q;
    assign id_valid    = valid;
    assign id_instr    = head.instr;
    assign id_opcode   = opcode_of(head.instr);
    assign id_pc       = head.pc;
    assign id_pc_plus4 = head.pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, fill latency, streaming, stall,
// redirect (including misaligned and back-to-back) and mid-run reset.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    int passCount  = 0;
    int checkCount = 0;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory model: one-cycle latency, returns addr | 0x13
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr | 32'h13) : 32'hDEAD_BEEF;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one cycle, drive inputs 1 unit after the edge, settle before checks
    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    // Hold reset for two edges, then release mid-cycle; returns inside the first cycle after release
    task automatic do_reset();
        rst_n          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL rst_req: got %b expected 0", imem_req); else passCount++;
        checkCount++; if (id_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b expected 0", id_valid); else passCount++;
        checkCount++; if (id_instr !== 32'h13) $display("[TB] FAIL rst_instr: got %h expected 00000013", id_instr); else passCount++;
        checkCount++; if (id_pc !== 32'h0) $display("[TB] FAIL rst_pc: got %h expected 00000000", id_pc); else passCount++;
        checkCount++; if (id_pc_plus4 !== 32'h4) $display("[TB] FAIL rst_pc4: got %h expected 00000004", id_pc_plus4); else passCount++;
    endtask

    task automatic test_reset_release();
        do_reset();
        checkCount++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("[TB] FAIL rel_c0: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); else passCount++;
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("[TB] FAIL rel_c1: got req=%b addr=%h expected req=1 addr=00000004", imem_req, imem_addr); else passCount++;
        checkCount++; if (id_valid !== 1'b0) $display("[TB] FAIL rel_c1_valid: got %b expected 0", id_valid); else passCount++;
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) $display("[TB] FAIL rel_c2: got req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr); else passCount++;
        checkCount++; if (id_valid !== 1'b1) $display("[TB] FAIL rel_c2_valid: got %b expected 1", id_valid); else passCount++;
        checkCount++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) $display("[TB] FAIL rel_c2_pc: got pc=%h pc4=%h expected 00000000/00000004", id_pc, id_pc_plus4); else passCount++;
        checkCount++; if (id_instr !== 32'h13 || id_opcode !== 7'h13) $display("[TB] FAIL rel_c2_instr: got %h op=%h expected 00000013 op=13", id_instr, id_opcode); else passCount++;
    endtask

    task automatic test_sustained();
        logic [31:0] expPc;
        do_reset();
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        expPc = 32'h0;
        for (int i = 0; i < 20; i++) begin
            checkCount++; if (id_valid !== 1'b1 || id_pc !== expPc) $display("[TB] FAIL stream_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", i, id_valid, id_pc, expPc); else passCount++;
            checkCount++; if (id_instr !== (expPc | 32'h13) || id_pc_plus4 !== expPc + 32'h4) $display("[TB] FAIL stream_data[%0d]: got instr=%h pc4=%h expected %h/%h", i, id_instr, id_pc_plus4, expPc | 32'h13, expPc + 32'h4); else passCount++;
            checkCount++; if (imem_req !== 1'b1 || imem_addr !== expPc + 32'h8) $display("[TB] FAIL stream_req[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, expPc + 32'h8); else passCount++;
            expPc = expPc + 32'h4;
            cyc(1'b1, 1'b0, '0);
        end
    endtask

    task automatic test_stall();
        logic [31:0] expPc;
        do_reset();
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, '0);
            checkCount++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h13) $display("[TB] FAIL stall_hold[%0d]: got valid=%b pc=%h instr=%h expected 1/00000000/00000013", i, id_valid, id_pc, id_instr); else passCount++;
            checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL stall_req[%0d]: got %b expected 0", i, imem_req); else passCount++;
        end
        expPc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, '0);
            checkCount++; if (id_valid !== 1'b1 || id_pc !== expPc) $display("[TB] FAIL drain_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", i, id_valid, id_pc, expPc); else passCount++;
            checkCount++; if (imem_req !== 1'b1 || imem_addr !== expPc + 32'h8) $display("[TB] FAIL drain_req[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, expPc + 32'h8); else passCount++;
            expPc = expPc + 32'h4;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) $display("[TB] FAIL redir_pre: got req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr); else passCount++;
        cyc(1'b1, 1'b1, 32'h100);
        checkCount++; if (id_valid !== 1'b0 || imem_req !== 1'b0) $display("[TB] FAIL redir_cycle: got valid=%b req=%b expected 0/0", id_valid, imem_req); else passCount++;
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0) $display("[TB] FAIL redir_issue: got req=%b addr=%h valid=%b expected 1/00000100/0", imem_req, imem_addr, id_valid); else passCount++;
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (id_valid !== 1'b0 || imem_addr !== 32'h104) $display("[TB] FAIL redir_gap: got valid=%b addr=%h expected 0/00000104", id_valid, imem_addr); else passCount++;
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_pc_plus4 !== 32'h104) $display("[TB] FAIL redir_first: got valid=%b pc=%h pc4=%h expected 1/00000100/00000104", id_valid, id_pc, id_pc_plus4); else passCount++;
        checkCount++; if (id_instr !== 32'h113) $display("[TB] FAIL redir_instr: got %h expected 00000113", id_instr); else passCount++;
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (id_valid !== 1'b1 || id_pc !== 32'h104) $display("[TB] FAIL redir_second: got valid=%b pc=%h expected 1/00000104", id_valid, id_pc); else passCount++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, 32'h103);
        checkCount++; if (imem_req !== 1'b0 || id_valid !== 1'b0) $display("[TB] FAIL mis_cycle: got req=%b valid=%b expected 0/0", imem_req, id_valid); else passCount++;
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("[TB] FAIL mis_align: got req=%b addr=%h expected 1/00000100", imem_req, imem_addr); else passCount++;
        cyc(1'b1, 1'b1, 32'h200);
        checkCount++; if (imem_req !== 1'b0 || id_valid !== 1'b0) $display("[TB] FAIL b2b_first: got req=%b valid=%b expected 0/0", imem_req, id_valid); else passCount++;
        cyc(1'b1, 1'b1, 32'h300);
        checkCount++; if (imem_req !== 1'b0 || id_valid !== 1'b0) $display("[TB] FAIL b2b_second: got req=%b valid=%b expected 0/0", imem_req, id_valid); else passCount++;
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || id_valid !== 1'b0) $display("[TB] FAIL b2b_issue: got req=%b addr=%h valid=%b expected 1/00000300/0", imem_req, imem_addr, id_valid); else passCount++;
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (id_valid !== 1'b0 || imem_addr !== 32'h304) $display("[TB] FAIL b2b_gap: got valid=%b addr=%h expected 0/00000304", id_valid, imem_addr); else passCount++;
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (id_valid !== 1'b1 || id_pc !== 32'h300) $display("[TB] FAIL b2b_deliver: got valid=%b pc=%h expected 1/00000300", id_valid, id_pc); else passCount++;
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (id_valid !== 1'b1 || id_pc !== 32'h304) $display("[TB] FAIL b2b_next: got valid=%b pc=%h expected 1/00000304", id_valid, id_pc); else passCount++;
    endtask

    task automatic test_reset_mid();
        // Reset while a request is being issued: imem_req must drop with no edge
        do_reset();
        checkCount++; if (imem_req !== 1'b1) $display("[TB] FAIL mid_pre_req: got %b expected 1", imem_req); else passCount++;
        #1;
        rst_n = 1'b0;
        #1;
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL mid_req_drop: got %b expected 0", imem_req); else passCount++;

        // Reset while stalled with a full FIFO
        do_reset();
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        checkCount++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || imem_req !== 1'b0) $display("[TB] FAIL mid_full: got valid=%b pc=%h req=%b expected 1/00000000/0", id_valid, id_pc, imem_req); else passCount++;
        #1;
        rst_n = 1'b0;
        #1;
        checkCount++; if (id_valid !== 1'b0 || imem_req !== 1'b0) $display("[TB] FAIL mid_async: got valid=%b req=%b expected 0/0", id_valid, imem_req); else passCount++;
        checkCount++; if (id_instr !== 32'h13 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) $display("[TB] FAIL mid_fields: got %h/%h/%h expected 00000013/00000000/00000004", id_instr, id_pc, id_pc_plus4); else passCount++;

        do_reset();
        checkCount++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("[TB] FAIL mid_restart: got req=%b addr=%h expected 1/00000000", imem_req, imem_addr); else passCount++;
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (id_valid !== 1'b1 || id_pc !== 32'h0) $display("[TB] FAIL mid_deliver: got valid=%b pc=%h expected 1/00000000", id_valid, id_pc); else passCount++;
        cyc(1'b1, 1'b0, '0);
        checkCount++; if (id_valid !== 1'b1 || id_pc !== 32'h4) $display("[TB] FAIL mid_next: got valid=%b pc=%h expected 1/00000004", id_valid, id_pc); else passCount++;
    endtask

    // Scenario sequence
    initial begin
        rst_n          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        test_reset();
        test_reset_release();
        test_sustained();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
